countdown_timer: RTL

//  MM:SS countdown timer (max 59:59) for the ChronoX clock. Loads a BCD preset
//  and counts down at 1 Hz with start/pause/clear keys. At 00:00 it raises
//  `alarm` for ALARM_SEC seconds. `alarm` drives the LED-blinker enable downstream.
//  Key inputs are single-cycle pulses from the existing debounce stage.

---
 rtl/countdown_timer_pkg.sv | 54 +++++
 rtl/tick_gen.sv | 39 +++
 rtl/countdown_timer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer: FSM states, BCD limits,
// the packed MM:SS digit record and the borrow-chain decrement.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StAlarm = 2'd3
    } state_e;

    localparam int unsigned DefaultClkFreq = 50_000_000;

    localparam logic [3:0] OnesMax = 4'd9;
    localparam logic [2:0] TensMax = 3'd5;

    typedef struct packed {
        logic [2:0] min_t;
        logic [3:0] min_o;
        logic [2:0] sec_t;
        logic [3:0] sec_o;
    } mmss_t;

    localparam mmss_t MmssZero = '0;

    function automatic logic mmss_valid(input mmss_t v);
        return (v.min_t <= TensMax) && (v.min_o <= OnesMax) &&
               (v.sec_t <= TensMax) && (v.sec_o <= OnesMax);
    endfunction

    // Caller guarantees v != 00:00, so min_t never underflows.
    function automatic mmss_t mmss_dec(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.sec_o != 4'd0) begin
            r.sec_o = v.sec_o - 4'd1;
        end else begin
            r.sec_o = OnesMax;
            if (v.sec_t != 3'd0) begin
                r.sec_t = v.sec_t - 3'd1;
            end else begin
                r.sec_t = TensMax;
                if (v.min_o != 4'd0) begin
                    r.min_o = v.min_o - 4'd1;
                end else begin
                    r.min_o = OnesMax;
                    r.min_t = v.min_t - 3'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// 1 Hz prescaler: counts 0..CLK_FREQ-1 while run is high and pulses tick on the last count.
// Holds its value while run is low; clr forces it back to zero.
module tick_gen
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DefaultClkFreq
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_FREQ - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run & ~clr & (cnt_q == CntMax);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: BCD preset load, 1 Hz countdown with start/pause/clear keys,
// and a timed alarm phase once the count reaches 00:00.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DefaultClkFreq,
    parameter int unsigned ALARM_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_clr,
    input  logic       key_load,
    input  logic [2:0] pre_min_t,
    input  logic [3:0] pre_min_o,
    input  logic [2:0] pre_sec_t,
    input  logic [3:0] pre_sec_o,
    output logic [2:0] min_t,
    output logic [3:0] min_o,
    output logic [2:0] sec_t,
    output logic [3:0] sec_o,
    output logic       running,
    output logic       alarm
);

    localparam logic [7:0] AlarmInit = 8'(ALARM_SEC - 1);

    state_e     state_q, state_d;
    mmss_t      digits_q, digits_d;
    logic [7:0] alarm_cnt_q, alarm_cnt_d;
    logic       running_q, alarm_q;

    mmss_t preset;
    logic  tick;
    logic  presc_run;
    logic  presc_clr;
    logic  any_key;

    assign preset    = {pre_min_t, pre_min_o, pre_sec_t, pre_sec_o};
    assign presc_run = (state_q == StRun) || (state_q == StAlarm);
    assign presc_clr = (state_q == StIdle);
    assign any_key   = key_start | key_clr | key_load;

    tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .run (presc_run),
        .clr (presc_clr),
        .tick(tick)
    );

    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        alarm_cnt_d = alarm_cnt_q;
        unique case (state_q)
            StIdle: begin
                alarm_cnt_d = '0;
                if (key_clr) begin
                    digits_d = MmssZero;
                end else if (key_start) begin
                    if (digits_q != MmssZero) begin
                        state_d = StRun;
                    end
                end else if (key_load && mmss_valid(preset)) begin
                    digits_d = preset;
                end
            end
            StRun: begin
                // Acting on a key takes precedence over a tick landing in the same cycle.
                if (key_clr) begin
                    state_d  = StIdle;
                    digits_d = MmssZero;
                end else if (key_start) begin
                    state_d = StPause;
                end else if (tick && (digits_q != MmssZero)) begin
                    digits_d = mmss_dec(digits_q);
                    if (digits_d == MmssZero) begin
                        state_d     = StAlarm;
                        alarm_cnt_d = AlarmInit;
                    end
                end
            end
            StPause: begin
                if (key_clr) begin
                    state_d  = StIdle;
                    digits_d = MmssZero;
                end else if (key_start) begin
                    state_d = StRun;
                end
            end
            StAlarm: begin
                digits_d = MmssZero;
                if (any_key) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (alarm_cnt_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                digits_d = MmssZero;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            digits_q    <= MmssZero;
            alarm_cnt_q <= '0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            alarm_cnt_q <= alarm_cnt_d;
            running_q   <= (state_d == StRun);
            alarm_q     <= (state_d == StAlarm);
        end
    end

    assign min_t   = digits_q.min_t;
    assign min_o   = digits_q.min_o;
    assign sec_t   = digits_q.sec_t;
    assign sec_o   = digits_q.sec_o;
    assign running = running_q;
    assign alarm   = alarm_q;

endmodule
